mem_arbiter: RTL and testbench

//  Shares the single-port unified program/data memory between three requesters: the UART

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/mem_addr_check.sv | 25 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the unified memory path: requester ids, field widths,
// and the registered response state used by the memory arbiter.
package riscv_pkg;

  localparam logic [31:0] MEM_BASE = 32'h8000_0000;
  localparam int          NREQ     = 3;
  localparam int          XLEN     = 32;
  localparam int          BEW      = XLEN / 8;

  typedef enum logic [1:0] {
    REQ_LD = 2'd0,
    REQ_DM = 2'd1,
    REQ_IF = 2'd2
  } req_id_t;

  // One response is in flight at most; pending is the one-hot owner of that response.
  typedef struct packed {
    logic [NREQ-1:0] pending;
    logic            err;
    logic            is_read;
  } rsp_state_t;

endpackage

// File: rtl/mem_addr_check.sv
// Byte address to word index translation with legality check against the memory window.
// Purely combinational so the loader can reuse it for bounds feedback.
module mem_addr_check
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE  = MEM_BASE,
  parameter int          DEPTH = 2056,
  parameter int          IDXW  = 12
) (
  input  logic [31:0]     addr_i,
  output logic [IDXW-1:0] idx_o,
  output logic            err_o
);

  logic [31:0] off;
  logic [29:0] word;

  assign off  = addr_i - BASE;
  assign word = off[31:2];

  // Below-base addresses wrap to huge offsets, but are flagged explicitly as well.
  assign err_o = (addr_i < BASE) | (off[1:0] != 2'b00) | ({2'b00, word} >= 32'(DEPTH));
  assign idx_o = word[IDXW-1:0];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified memory between loader, data port and fetch, with a
// fixed one-cycle registered response per accepted request.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = riscv_pkg::MEM_BASE,
  parameter int          DEPTH    = 2056,
  parameter int          IDXW     = 12,
  parameter int          CNTW     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*XLEN-1:0] req_addr,
  input  logic [NREQ*BEW-1:0]  req_be,
  input  logic [NREQ*XLEN-1:0] req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic                 rsp_err,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [BEW-1:0]       mem_be,
  output logic [IDXW-1:0]      mem_idx,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic [CNTW-1:0]      conflict_cnt
);

  // Handshake: a request from requester i is accepted in the cycle where
  // req_valid[i] & req_ready[i]; req_ready is one-hot or zero and never depends on
  // mem_rdata, and the response follows exactly one cycle after acceptance.

  logic [NREQ-1:0] grant;
  logic [XLEN-1:0] sel_addr;
  logic [XLEN-1:0] sel_wdata;
  logic [BEW-1:0]  sel_be;
  logic            sel_we;
  logic            accept;
  logic            chk_err;
  logic [IDXW-1:0] chk_idx;
  logic            conflict;

  rsp_state_t      rsp_q, rsp_d;
  req_id_t         rr_last_q, rr_last_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Loader wins outright; data port and fetch alternate when they collide.
  always_comb begin
    grant = '0;
    if (!reset) begin
      if (req_valid[REQ_LD]) begin
        grant[REQ_LD] = 1'b1;
      end else if (req_valid[REQ_DM] && req_valid[REQ_IF]) begin
        if (rr_last_q == REQ_DM) grant[REQ_IF] = 1'b1;
        else                     grant[REQ_DM] = 1'b1;
      end else if (req_valid[REQ_DM]) begin
        grant[REQ_DM] = 1'b1;
      end else if (req_valid[REQ_IF]) begin
        grant[REQ_IF] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[XLEN*i +: XLEN];
        sel_wdata = req_wdata[XLEN*i +: XLEN];
        sel_be    = req_be[BEW*i +: BEW];
        sel_we    = req_we[i];
      end
    end
  end

  mem_addr_check #(
    .BASE  (MEM_BASE),
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_addr_check (
    .addr_i (sel_addr),
    .idx_o  (chk_idx),
    .err_o  (chk_err)
  );

  assign accept    = |grant;
  assign req_ready = grant;

  // Illegal addresses are still accepted and answered, but never reach the array.
  assign mem_en    = accept & ~chk_err;
  assign mem_we    = mem_en & sel_we;
  assign mem_be    = accept ? sel_be : '0;
  assign mem_idx   = mem_en ? chk_idx : '0;
  assign mem_wdata = accept ? sel_wdata : '0;

  assign conflict = (req_valid[0] & req_valid[1]) |
                    (req_valid[0] & req_valid[2]) |
                    (req_valid[1] & req_valid[2]);

  always_comb begin
    rsp_d.pending = grant;
    rsp_d.err     = accept & chk_err;
    rsp_d.is_read = accept & ~sel_we;

    rr_last_d = rr_last_q;
    if (grant[REQ_DM])      rr_last_d = REQ_DM;
    else if (grant[REQ_IF]) rr_last_d = REQ_IF;

    cnt_d = cnt_q;
    if (conflict && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q     <= '0;
      rr_last_q <= REQ_IF;
      cnt_q     <= '0;
    end else begin
      rsp_q     <= rsp_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
    end
  end

  // Gating with reset drops a response that falls due in the reset cycle itself.
  assign rsp_valid    = rsp_q.pending & {NREQ{~reset}};
  assign rsp_err      = rsp_q.err & ~reset;
  assign rsp_rdata    = (~reset & rsp_q.is_read & ~rsp_q.err) ? mem_rdata : '0;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: a transaction-level predictor pushes
// expected responses, an independent monitor pops them when the DUT answers.
module tb_mem_arbiter;
  import riscv_pkg::*;

  localparam int          DEPTH = 2056;
  localparam int          IDXW  = 12;
  localparam int          CNTW  = 16;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          W     = 68;   // {due cycle[31:0], rsp_valid[2:0], err, rdata[31:0]}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]       req_valid = '0;
  logic [2:0]       req_we    = '0;
  logic [95:0]      req_addr  = '0;
  logic [11:0]      req_be    = '0;
  logic [95:0]      req_wdata = '0;
  logic [2:0]       req_ready;
  logic [2:0]       rsp_valid;
  logic             rsp_err;
  logic [31:0]      rsp_rdata;
  logic             mem_en;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [IDXW-1:0]  mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata = '0;
  logic [CNTW-1:0]  conflict_cnt;

  mem_arbiter #(
    .MEM_BASE (BASE),
    .DEPTH    (DEPTH),
    .IDXW     (IDXW),
    .CNTW     (CNTW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_be       (req_be),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_idx      (mem_idx),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'hDEAD_BEEF;
    if (i == 4) return 32'h1122_3344;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- memory array (environment) ----------------
  logic [31:0] mem [DEPTH];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_idx];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: requester choice, address legality and memory contents at the
  // transaction level, one decision per cycle.
  logic [31:0] ref_mem [DEPTH];
  int          m_last;
  int          m_cnt;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    m_last = 2;
    m_cnt  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("ready_in_reset", 64'(req_ready), 64'd0);
        while (exp_q.size() > 0 && exp_q[0][67:36] == 32'(cyc)) void'(exp_q.pop_front());
        m_last = 2;
        m_cnt  = 0;
      end else begin
        int          g;
        int          nv;
        logic [31:0] a;
        longint      la;
        bit          legal;
        int          idx;
        logic [31:0] exp_rd;
        logic [2:0]  exp_rdy;

        g = -1;
        if (req_valid[0])                      g = 0;
        else if (req_valid[1] && req_valid[2]) g = (m_last == 1) ? 2 : 1;
        else if (req_valid[1])                 g = 1;
        else if (req_valid[2])                 g = 2;
        exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
        check("grant", 64'(req_ready), 64'(exp_rdy));
        check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));

        if (g < 0) begin
          check("mem_en_idle", 64'(mem_en), 64'd0);
        end else begin
          a     = req_addr[32*g +: 32];
          la    = longint'(a);
          legal = (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH) && (la % 4 == 0);
          idx   = legal ? int'((la - longint'(BASE)) / 4) : 0;
          check("mem_en", 64'(mem_en), 64'(legal));
          exp_rd = '0;
          if (legal) begin
            check("mem_idx", 64'(mem_idx), 64'(idx));
            check("mem_we", 64'(mem_we), 64'(req_we[g]));
            if (req_we[g]) begin
              check("mem_be", 64'(mem_be), 64'(req_be[4*g +: 4]));
              check("mem_wdata", 64'(mem_wdata), 64'(req_wdata[32*g +: 32]));
              for (int b = 0; b < 4; b++)
                if (req_be[4*g + b]) ref_mem[idx][8*b +: 8] = req_wdata[32*g + 8*b +: 8];
            end else begin
              exp_rd = ref_mem[idx];
            end
          end
          exp_q.push_back({32'(cyc + 1), exp_rdy, !legal, exp_rd});
          if (g != 0) m_last = g;
        end

        nv = int'(req_valid[0]) + int'(req_valid[1]) + int'(req_valid[2]);
        if (nv >= 2 && m_cnt < (1 << CNTW) - 1) m_cnt++;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the head of the queue.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0 && exp_q[0][67:36] == 32'(cyc)) begin
        e = exp_q.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(e[35:33]));
        check("rsp_err", 64'(rsp_err), 64'(e[32]));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
      end else if (rsp_valid != 3'b000) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    req_valid[i]         = 1'b1;
    req_we[i]            = we;
    req_addr[32*i +: 32] = addr;
    req_be[4*i +: 4]     = be;
    req_wdata[32*i +: 32] = wd;
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 11))
      0:       return BASE - 32'(4 * $urandom_range(1, 4));
      1:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
      2:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      3:       return BASE + 32'(4 * (DEPTH - 1));
      4:       return 32'hFFFF_FFFC;
      5:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      default: return BASE + 32'(4 * $urandom_range(0, 15));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    clear_all();
    repeat (3) step();
    reset = 1'b0;

    // Single read of word 0 by fetch.
    set_req(2, 1'b0, BASE, 4'h0, 32'h0);
    step();
    clear_all();
    step();

    // Priority and round-robin: expected grants 0,1,2,1 and four conflict cycles.
    pulse_reset();
    set_req(0, 1'b0, BASE + 32'h20, 4'h0, 32'h0);
    set_req(1, 1'b0, BASE + 32'h24, 4'h0, 32'h0);
    set_req(2, 1'b0, BASE + 32'h28, 4'h0, 32'h0);
    step();
    req_valid[0] = 1'b0;
    repeat (3) step();
    clear_all();
    step();
    check("conflict_cnt_after_tie", 64'(conflict_cnt), 64'd4);

    // Address errors from the data port.
    set_req(1, 1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0);
    step();
    set_req(1, 1'b0, 32'h8000_0002, 4'h0, 32'h0);
    step();
    set_req(1, 1'b0, BASE + 32'(4 * DEPTH), 4'h0, 32'h0);
    step();
    clear_all();
    step();

    // Byte-lane write then immediate read of the same word.
    set_req(1, 1'b1, 32'h8000_0010, 4'b0010, 32'h0000_AB00);
    step();
    clear_all();
    set_req(2, 1'b0, 32'h8000_0010, 4'h0, 32'h0);
    step();
    clear_all();
    step();
    check("ref_merged_word", 64'(ref_mem[4]), 64'h1122_AB44);

    // Reset the cycle after a fetch read is accepted: that response must never appear.
    set_req(2, 1'b0, BASE + 32'h8, 4'h0, 32'h0);
    step();
    clear_all();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    set_req(1, 1'b0, BASE + 32'hC, 4'h0, 32'h0);
    set_req(2, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
    #1;
    check("rr_after_reset", 64'(req_ready), 64'b010);
    step();
    clear_all();
    step();

    // Randomised traffic with occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      clear_all();
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 99) < (i == 0 ? 15 : 55))
          set_req(i, 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom_range(0, 15)), $urandom);
      end
      reset = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0;
    clear_all();
    step();

    // Counter saturation with data port and fetch colliding continuously.
    pulse_reset();
    set_req(1, 1'b0, BASE + 32'h40, 4'h0, 32'h0);
    set_req(2, 1'b0, BASE + 32'h44, 4'h0, 32'h0);
    repeat ((1 << CNTW) + 5) step();
    check("conflict_cnt_saturated", 64'(conflict_cnt), 64'((1 << CNTW) - 1));
    clear_all();
    repeat (3) step();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
